// File: rtl/txn_circular_buffer.sv
// Circular buffer with transactional writes: words written inside a mark/commit
// window occupy space but stay invisible to the reader until committed.
module txn_circular_buffer #(
  parameter int DATA_WIDTH        = 8,
  parameter int ADDR_WIDTH        = 8,
  parameter int ALMOST_FULL_LEVEL = (1 << ADDR_WIDTH) - 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_write_en,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_read_en,
  input  logic                  i_mark,
  input  logic                  i_commit,
  input  logic                  i_rollback,
  input  logic                  i_clear_errors,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_almost_full,
  output logic [ADDR_WIDTH:0]   o_used,
  output logic [ADDR_WIDTH:0]   o_avail,
  output logic                  o_txn_open,
  output logic                  o_overrun,
  output logic                  o_underrun,
  output logic                  o_invalid_operation
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH:0] commit_ptr_q, commit_ptr_d;
  logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
  logic                txn_open_q, txn_open_d;
  logic                overrun_q, overrun_d;
  logic                underrun_q, underrun_d;
  logic                invalid_q, invalid_d;

  logic [ADDR_WIDTH:0] used, avail;
  logic                full, empty;
  logic                rd_accept, wr_accept, wr_do;
  logic                multi_ctl, mark_ok, commit_ok, rollback_ok, bad_ctl;

  always_comb begin
    used  = wr_ptr_q - rd_ptr_q;
    avail = commit_ptr_q - rd_ptr_q;
    full  = (used == DEPTH_CNT);
    empty = (avail == '0);
  end

  always_comb begin
    multi_ctl   = (i_mark & i_commit) | (i_mark & i_rollback) | (i_commit & i_rollback);
    mark_ok     = i_mark     & ~multi_ctl & ~txn_open_q;
    commit_ok   = i_commit   & ~multi_ctl &  txn_open_q;
    rollback_ok = i_rollback & ~multi_ctl &  txn_open_q;
    bad_ctl     = multi_ctl | (i_mark & txn_open_q) | ((i_commit | i_rollback) & ~txn_open_q);
  end

  // A write into a full buffer is only accepted when a read frees a slot in
  // the same cycle; a rollback swallows the write without flagging overrun.
  always_comb begin
    rd_accept = i_read_en & ~empty;
    wr_accept = i_write_en & (~full | rd_accept);
    wr_do     = wr_accept & ~rollback_ok;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q + {{ADDR_WIDTH{1'b0}}, rd_accept};

    if (rollback_ok) wr_ptr_d = commit_ptr_q;
    else             wr_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_do};

    // commit_ptr doubles as the checkpoint: it is frozen while a transaction
    // is open, and a write in the marking cycle already belongs to the txn.
    if (commit_ok)                    commit_ptr_d = wr_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_do};
    else if (!txn_open_q && !mark_ok) commit_ptr_d = commit_ptr_q + {{ADDR_WIDTH{1'b0}}, wr_do};
    else                              commit_ptr_d = commit_ptr_q;

    txn_open_d = txn_open_q;
    if (mark_ok)                  txn_open_d = 1'b1;
    if (commit_ok || rollback_ok) txn_open_d = 1'b0;

    overrun_d  = (overrun_q  & ~i_clear_errors) | (i_write_en & ~wr_accept & ~rollback_ok);
    underrun_d = (underrun_q & ~i_clear_errors) | (i_read_en & empty);
    invalid_d  = (invalid_q  & ~i_clear_errors) | bad_ctl;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q     <= '0;
      commit_ptr_q <= '0;
      rd_ptr_q     <= '0;
      txn_open_q   <= 1'b0;
      overrun_q    <= 1'b0;
      underrun_q   <= 1'b0;
      invalid_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      commit_ptr_q <= commit_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      txn_open_q   <= txn_open_d;
      overrun_q    <= overrun_d;
      underrun_q   <= underrun_d;
      invalid_q    <= invalid_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && wr_do) mem[wr_ptr_q[ADDR_WIDTH-1:0]] <= i_data;
  end

  always_comb begin
    o_data              = mem[rd_ptr_q[ADDR_WIDTH-1:0]];
    o_empty             = empty;
    o_full              = full;
    o_almost_full       = int'(used) >= ALMOST_FULL_LEVEL;
    o_used              = used;
    o_avail             = avail;
    o_txn_open          = txn_open_q;
    o_overrun           = overrun_q;
    o_underrun          = underrun_q;
    o_invalid_operation = invalid_q;
  end

endmodule
